// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the data memory responder.
// Holds the I/O register offsets, the legal byte-lane masks, the default
// RAM size and I/O base, the address-decode select type, and helpers that
// turn a lane mask into a shift amount and a width mask.
package mem_map_pkg;

    localparam int          RAM_WORDS_DEF = 1024;
    localparam logic [31:0] IO_BASE_DEF   = 32'h1000_0000;

    // I/O register offsets from IO_BASE
    localparam logic [31:0] OFF_TCOUNT = 32'h0000_0000;
    localparam logic [31:0] OFF_TCMP   = 32'h0000_0004;
    localparam logic [31:0] OFF_TSTAT  = 32'h0000_0008;
    localparam logic [31:0] OFF_GOUT   = 32'h0000_0010;
    localparam logic [31:0] OFF_GIN    = 32'h0000_0014;

    // Legal byte-lane masks
    localparam logic [3:0] MASK_W  = 4'b1111;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TCOUNT,
        SEL_TCMP,
        SEL_TSTAT,
        SEL_GOUT,
        SEL_GIN
    } sel_e;

    function automatic logic mask_legal(input logic [3:0] m);
        case (m)
            MASK_W, MASK_H0, MASK_H1,
            MASK_B0, MASK_B1, MASK_B2, MASK_B3: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Bit position of the lowest selected lane
    function automatic logic [4:0] lane_shift(input logic [3:0] m);
        case (m)
            MASK_H1, MASK_B2: return 5'd16;
            MASK_B1:          return 5'd8;
            MASK_B3:          return 5'd24;
            default:          return 5'd0;
        endcase
    endfunction

    // Right-justified width mask of the access
    function automatic logic [31:0] lane_width(input logic [3:0] m);
        case (m)
            MASK_W:           return 32'hFFFF_FFFF;
            MASK_H0, MASK_H1: return 32'h0000_FFFF;
            default:          return 32'h0000_00FF;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane alignment for loads and stores.
// Ports:
//   r_mask    - read lane mask; selects which lanes of word are extracted
//   w_mask    - write lane mask; selects which lanes of word are replaced
//   word      - addressed 32-bit word (current contents)
//   data      - right-justified store data
//   extracted - selected read lanes shifted down to bit 0, zero-extended
//   merged    - word with the selected write lanes replaced by data
module lane_align
    import mem_map_pkg::*;
(
    input  logic [3:0]  r_mask,
    input  logic [3:0]  w_mask,
    input  logic [31:0] word,
    input  logic [31:0] data,
    output logic [31:0] extracted,
    output logic [31:0] merged
);

    logic [31:0] byte_en;

    always_comb begin
        byte_en   = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
        extracted = (word >> lane_shift(r_mask)) & lane_width(r_mask);
        merged    = (word & ~byte_en) | ((data << lane_shift(w_mask)) & byte_en);
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data memory responder: word RAM plus a small I/O window (timer, GPIO).
// Reads are combinational; writes commit at the rising edge of clk.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   memCe             - access enable
//   memWr, memRr      - write / read request
//   memAddr           - byte address
//   wtData            - right-justified store data
//   w_mask, r_mask    - write / read byte-lane masks
//   rdData            - right-justified load data (combinational)
//   gpio_in, gpio_out - external input pins / registered output pins
//   timer_irq         - TIMER_STAT bit0
//   bus_err           - sticky flag for illegal mask / unmapped / RO write
module data_mem_resp
    import mem_map_pkg::*;
#(
    parameter int          RAM_WORDS = RAM_WORDS_DEF,
    parameter logic [31:0] IO_BASE   = IO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memCe,
    input  logic        memWr,
    input  logic        memRr,
    input  logic [31:0] memAddr,
    input  logic [31:0] wtData,
    input  logic [3:0]  w_mask,
    input  logic [3:0]  r_mask,
    output logic [31:0] rdData,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        timer_irq,
    output logic        bus_err
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] t_count, t_cmp, count_next;
    logic        t_stat;
    logic [15:0] sync1, sync2;

    sel_e        sel;
    logic [31:0] sel_word, extracted, merged;
    logic        mask_ok, err, wr_ok, ram_we, w1c, stat_set;

    // Address decode
    always_comb begin
        sel = SEL_NONE;
        if (memAddr[31:AW+2] == '0)            sel = SEL_RAM;
        else if (memAddr == IO_BASE + OFF_TCOUNT) sel = SEL_TCOUNT;
        else if (memAddr == IO_BASE + OFF_TCMP)   sel = SEL_TCMP;
        else if (memAddr == IO_BASE + OFF_TSTAT)  sel = SEL_TSTAT;
        else if (memAddr == IO_BASE + OFF_GOUT)   sel = SEL_GOUT;
        else if (memAddr == IO_BASE + OFF_GIN)    sel = SEL_GIN;
    end

    always_comb begin
        case (sel)
            SEL_RAM:    sel_word = ram[memAddr[AW+1:2]];
            SEL_TCOUNT: sel_word = t_count;
            SEL_TCMP:   sel_word = t_cmp;
            SEL_TSTAT:  sel_word = {31'd0, t_stat};
            SEL_GOUT:   sel_word = {16'd0, gpio_out};
            SEL_GIN:    sel_word = {16'd0, sync2};
            default:    sel_word = 32'd0;
        endcase
    end

    // Shared lane logic: extract for loads, merge for stores. The merge uses
    // the pre-write word, so a same-cycle read sees old data.
    lane_align u_lane_align (
        .r_mask    (r_mask),
        .w_mask    (w_mask),
        .word      (sel_word),
        .data      (wtData),
        .extracted (extracted),
        .merged    (merged)
    );

    // Only the mask of an actually requested direction has to be legal
    assign mask_ok = (!memRr || mask_legal(r_mask)) && (!memWr || mask_legal(w_mask));
    assign err     = memCe && (memRr || memWr) &&
                     (!mask_ok || sel == SEL_NONE || (memWr && sel == SEL_GIN));
    assign wr_ok   = memCe && memWr && !err;
    assign rdData  = (memCe && memRr && mask_ok && sel != SEL_NONE) ? extracted : 32'd0;

    // RAM is never reset, but a write seen while rst is high is dropped
    assign ram_we  = wr_ok && sel == SEL_RAM && !rst;

    always_ff @(posedge clk) begin
        if (ram_we) ram[memAddr[AW+1:2]] <= merged;
    end

    // CPU write wins over the free-running increment
    assign count_next = (wr_ok && sel == SEL_TCOUNT) ? merged : t_count + 32'd1;
    assign stat_set   = (count_next == t_cmp);
    // Write-one-to-clear needs lane 0 selected with a 1 in data bit 0
    assign w1c        = wr_ok && sel == SEL_TSTAT && w_mask[0] && wtData[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_count  <= 32'd0;
            t_cmp    <= 32'hFFFF_FFFF;
            t_stat   <= 1'b0;
            gpio_out <= 16'd0;
            sync1    <= 16'd0;
            sync2    <= 16'd0;
            bus_err  <= 1'b0;
        end else begin
            t_count <= count_next;
            sync1   <= gpio_in;
            sync2   <= sync1;
            if (wr_ok && sel == SEL_TCMP) t_cmp    <= merged;
            if (wr_ok && sel == SEL_GOUT) gpio_out <= merged[15:0];
            if (stat_set)                 t_stat   <= 1'b1;
            else if (w1c)                 t_stat   <= 1'b0;
            if (err)                      bus_err  <= 1'b1;
        end
    end

    assign timer_irq = t_stat;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench for data_mem_resp.
module tb_data_mem_resp;

    localparam logic [31:0] IO = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        memCe, memWr, memRr;
    logic [31:0] memAddr, wtData;
    logic [3:0]  w_mask, r_mask;
    logic [31:0] rdData;
    logic [15:0] gpio_in, gpio_out;
    logic        timer_irq, bus_err;

    int n_pass  = 0;
    int n_total = 0;

    data_mem_resp dut (
        .clk       (clk),
        .rst       (rst),
        .memCe     (memCe),
        .memWr     (memWr),
        .memRr     (memRr),
        .memAddr   (memAddr),
        .wtData    (wtData),
        .w_mask    (w_mask),
        .r_mask    (r_mask),
        .rdData    (rdData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        memCe = 0; memWr = 0; memRr = 0;
        memAddr = 0; wtData = 0; w_mask = 0; r_mask = 0;
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        memCe = 1; memWr = 1; memAddr = a; wtData = d; w_mask = m;
        step();
        idle();
    endtask

    // Combinational read, no clock edge consumed
    task automatic rd(input logic [31:0] a, input logic [3:0] m, output logic [31:0] d);
        memCe = 1; memRr = 1; memAddr = a; r_mask = m;
        #1 d = rdData;
        idle();
    endtask

    logic [31:0] v;

    initial begin
        rst = 1; gpio_in = 16'h0; idle();
        #2;
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_irq", {31'd0, timer_irq}, 32'd0);
        chk("rst_gpio_out", {16'd0, gpio_out}, 32'd0);
        chk("rd_idle", rdData, 32'd0);
        rd(IO + 32'h0, 4'b1111, v); chk("rst_tcount", v, 32'd0);
        rd(IO + 32'h4, 4'b1111, v); chk("rst_tcmp", v, 32'hFFFF_FFFF);
        step();
        rst = 0;

        // Word store / load, byte load
        wr(32'h40, 32'hDEAD_BEEF, 4'b1111);
        rd(32'h40, 4'b1111, v); chk("lw", v, 32'hDEAD_BEEF);
        rd(32'h40, 4'b0100, v); chk("lbu_lane2", v, 32'h0000_00AD);

        // Same-cycle read + halfword write returns old data
        memCe = 1; memRr = 1; memWr = 1; memAddr = 32'h40;
        r_mask = 4'b1111; w_mask = 4'b1100; wtData = 32'h0000_1234;
        #1 chk("rd_during_wr", rdData, 32'hDEAD_BEEF);
        step(); idle();
        rd(32'h40, 4'b1111, v); chk("sh_upper", v, 32'h1234_BEEF);
        rd(32'h40, 4'b1100, v); chk("lhu_upper", v, 32'h0000_1234);
        wr(32'h40, 32'h0000_0055, 4'b0010);
        rd(32'h40, 4'b1111, v); chk("sb_lane1", v, 32'h1234_55EF);

        // Timer compare: count 0 after the write, match at the 5th edge
        wr(IO + 32'h4, 32'd5, 4'b1111);
        wr(IO + 32'h0, 32'd0, 4'b1111);
        rd(IO + 32'h0, 4'b1111, v); chk("tcount_written", v, 32'd0);
        repeat (4) step();
        chk("irq_before_match", {31'd0, timer_irq}, 32'd0);
        wr(IO + 32'h8, 32'd1, 4'b0001);
        chk("irq_set_beats_w1c", {31'd0, timer_irq}, 32'd1);
        rd(IO + 32'h0, 4'b1111, v); chk("tcount_at_match", v, 32'd5);
        wr(IO + 32'h8, 32'd1, 4'b0001);
        chk("irq_w1c_clear", {31'd0, timer_irq}, 32'd0);
        rd(IO + 32'h8, 4'b1111, v); chk("tstat_clear", v, 32'd0);

        // Timer wrap
        wr(IO + 32'h0, 32'hFFFF_FFFF, 4'b1111);
        rd(IO + 32'h0, 4'b1111, v); chk("tcount_max", v, 32'hFFFF_FFFF);
        step();
        rd(IO + 32'h0, 4'b1111, v); chk("tcount_wrap", v, 32'd0);

        // Illegal mask: bus_err, RAM untouched, zero read data
        wr(32'h0, 32'h1122_3344, 4'b1111);
        chk("no_err_yet", {31'd0, bus_err}, 32'd0);
        rd(32'h0, 4'b0110, v); chk("rd_illegal_mask", v, 32'd0);
        rd(IO + 32'hC, 4'b1111, v); chk("rd_unmapped", v, 32'd0);
        wr(32'h0, 32'hFFFF_FFFF, 4'b0110);
        chk("bus_err_set", {31'd0, bus_err}, 32'd1);
        rd(32'h0, 4'b1111, v); chk("ram_unchanged", v, 32'h1122_3344);
        step();
        chk("bus_err_sticky", {31'd0, bus_err}, 32'd1);

        // GPIO input synchronizer and output register
        gpio_in = 16'hA5A5;
        step();
        rd(IO + 32'h14, 4'b1111, v); chk("gpio_in_1cyc", v, 32'd0);
        step();
        rd(IO + 32'h14, 4'b1111, v); chk("gpio_in_2cyc", v, 32'h0000_A5A5);
        wr(IO + 32'h10, 32'h0000_1234, 4'b1111);
        chk("gpio_out", {16'd0, gpio_out}, 32'h0000_1234);
        wr(IO + 32'h10, 32'h0000_00AB, 4'b0010);
        chk("gpio_out_byte", {16'd0, gpio_out}, 32'h0000_AB34);

        // Mid-run reset; a RAM write under reset is dropped
        rst = 1;
        #1;
        chk("mid_rst_gpio_out", {16'd0, gpio_out}, 32'd0);
        chk("mid_rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("mid_rst_irq", {31'd0, timer_irq}, 32'd0);
        rd(IO + 32'h0, 4'b1111, v); chk("mid_rst_tcount", v, 32'd0);
        rd(IO + 32'h4, 4'b1111, v); chk("mid_rst_tcmp", v, 32'hFFFF_FFFF);
        rd(IO + 32'h14, 4'b1111, v); chk("mid_rst_sync", v, 32'd0);
        wr(32'h40, 32'h0, 4'b1111);
        rst = 0;
        rd(32'h40, 4'b1111, v); chk("ram_kept", v, 32'h1234_55EF);
        step();
        chk("post_rst_bus_err", {31'd0, bus_err}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, number of 32-bit RAM words (power of two).
REQ-002 SHALL have parameter IO_BASE, default 32'h1000_0000, base address of the I/O register window.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port memCe  input  1  access enable; no access when low.
REQ-006 SHALL have port memWr  input  1  write request.
REQ-007 SHALL have port memRr  input  1  read request.
REQ-008 SHALL have port memAddr  input  32  byte address.
REQ-009 SHALL have port wtData  input  32  store data, right-justified.
REQ-010 SHALL have port w_mask  input  4  write byte-lane mask.
REQ-011 SHALL have port r_mask  input  4  read byte-lane mask.
REQ-012 SHALL have port rdData  output  32  load data, combinational, right-justified.
REQ-013 SHALL have port gpio_in  input  16  external input pins.
REQ-014 SHALL have port gpio_out  output  16  registered output pins.
REQ-015 SHALL have port timer_irq  output  1  equals TIMER_STAT bit0.
REQ-016 SHALL have port bus_err  output  1  sticky illegal-access flag.

Function
REQ-017 Legal masks SHALL be 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000; any other mask on an active request is illegal.
REQ-018 Map: RAM at 0 .. RAM_WORDS*4-1, word index memAddr[log2(RAM_WORDS)+1:2]; IO_BASE+0x0 TIMER_COUNT (RW), +0x4 TIMER_CMP (RW), +0x8 TIMER_STAT (bit0 W1C), +0x10 GPIO_OUT (RW, low 16 bits), +0x14 GPIO_IN (RO); everything else unmapped.
REQ-019 Read (memCe & memRr): rdData SHALL present the selected lanes of the addressed word shifted down to bit 0, zero-extended, in the same cycle (zero latency).
REQ-020 rdData SHALL be 0 when memCe low, memRr low, mask illegal, or address unmapped.
REQ-021 Write (memCe & memWr): wtData[7:0] / [15:0] / [31:0] SHALL be written into the selected lanes at the next rising edge; unselected lanes unchanged.
REQ-022 Simultaneous memRr and memWr to the same word SHALL return pre-write data on rdData and commit the write at the edge.
REQ-023 Illegal mask, unmapped address, or write to GPIO_IN SHALL set bus_err at the next edge; no state changes; bus_err clears only on reset.
REQ-024 TIMER_COUNT SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF -> 0; a CPU write in that cycle wins over the increment.
REQ-025 TIMER_STAT bit0 SHALL set at the edge where the next TIMER_COUNT value equals TIMER_CMP; a same-cycle W1C loses to the set.
REQ-026 Partial-lane writes to I/O registers SHALL update only the selected lanes, as in RAM.
REQ-027 GPIO_IN SHALL be sampled through a 2-flop synchronizer; reads return the second-stage value zero-extended.

Reset
REQ-028 On rst: TIMER_COUNT=0, TIMER_CMP=0xFFFF_FFFF, TIMER_STAT=0, GPIO_OUT=0, bus_err=0, synchronizer=0; rdData follows REQ-019/020.
REQ-029 RAM contents SHALL NOT be reset; a write pending at a reset edge is dropped.

Structure
REQ-030 Address offsets, legal-mask constants, and RAM_WORDS default SHALL live in shared package mem_map_pkg.
REQ-031 Lane extract/insert logic SHALL be one sub-module, lane_align, used for both read and write paths.

Verification
REQ-032 SW mask 1111 @0x40 data 0xDEADBEEF, then LW -> rdData=0xDEADBEEF; LBU mask 0100 @0x40 -> 0x000000AD.
REQ-033 SH mask 1100 @0x40 data 0x00001234 -> LW returns 0x1234BEEF; same-cycle read+write returns old 0xDEADBEEF.
REQ-034 Write TIMER_CMP=5, TIMER_COUNT=0 -> timer_irq high after 5 cycles; W1C in match cycle -> stays set; later W1C -> clears.
REQ-035 Write TIMER_COUNT=0xFFFF_FFFF -> next cycle reads 0; write mask 0110 @0x0 -> bus_err=1, RAM unchanged, rdData=0.
REQ-036 gpio_in=0xA5A5 -> GPIO_IN reads 0xA5A5 after 2 cycles; write GPIO_OUT 0x1234 -> gpio_out=0x1234; assert rst mid-run -> all REQ-028 values, RAM word 0x40 preserved.
